// File: rtl/bcx_pkg.sv
// bcx_pkg: shared block geometry, byte-count type and fill/full state for the block deserializer.
package bcx_pkg;
    localparam int BLOCK_BYTES = 44;
    localparam int STATE_WIDTH = 8 * BLOCK_BYTES;
    typedef logic [5:0] count_t;
    typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/byte_counter.sv
// byte_counter: byte position within a block; load-0 beats load-1 beats increment, increment wraps at LAST.
module byte_counter
    import bcx_pkg::*;
#(
    parameter count_t LAST = count_t'(BLOCK_BYTES - 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load0,
    input  logic   load1,
    input  logic   inc,
    output count_t count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load0) count <= '0;
        else if (load1) count <= count_t'(1);
        else if (inc) count <= (count == LAST) ? '0 : count + count_t'(1);
    end
endmodule

// File: rtl/block_deserializer.sv
// block_deserializer: packs a byte stream MSB-first into BLOCK_BYTES-wide blocks with a one-deep hold.
// Optional start-of-block resync and its discard counter are enabled by defining SOF_RESYNC_EN.
module block_deserializer #(
    parameter int BLOCK_BYTES = bcx_pkg::BLOCK_BYTES,
    parameter int STATE_WIDTH = 8 * BLOCK_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_valid,
    input  logic [7:0]             block_data,
    output logic                   write_ready,
    input  logic                   read,
    output logic                   full,
`ifdef SOF_RESYNC_EN
    input  logic                   block_start,
    output logic [7:0]             resync_count,
`endif
    output logic [STATE_WIDTH-1:0] out
);
    import bcx_pkg::*;
    state_t state;
    count_t count, idx;
    logic   accept, last, sof;
`ifdef SOF_RESYNC_EN
    assign sof = block_start & (state == FILL);
`else
    assign sof = 1'b0;
`endif
    assign write_ready = (state == FILL) | read;
    assign accept = write_valid & write_ready;
    // A byte taken while draining FULL, or flagged as start, always lands in slot 0.
    assign idx  = (state == FULL || sof) ? '0 : count;
    assign last = idx == count_t'(BLOCK_BYTES - 1);
    assign full = state == FULL;
    byte_counter #(.LAST(count_t'(BLOCK_BYTES - 1))) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load0 (accept & last),
        .load1 (accept & ~last & (idx == '0)),
        .inc   (accept),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else if (accept && last) state <= FULL;
        else if (state == FULL && read) state <= FILL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= '0;
        else if (accept)
            for (int i = 0; i < BLOCK_BYTES; i++)
                if (idx == count_t'(i)) out[STATE_WIDTH-1-8*i -: 8] <= block_data;
    end
`ifdef SOF_RESYNC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resync_count <= '0;
        else if (accept && sof && count != '0 && resync_count != 8'hFF) resync_count <= resync_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_block_deserializer.sv
// tb_block_deserializer: random and directed stimulus against a queue-based block assembly model.
module tb_block_deserializer;
    localparam int BB = 44;
    localparam int SW = 8 * BB;
`ifdef SOF_RESYNC_EN
    localparam bit SOF = 1'b1;
`else
    localparam bit SOF = 1'b0;
`endif
    logic          clk = 1'b0, rst_n = 1'b0, write_valid = 1'b0, read = 1'b0;
    logic [7:0]    block_data = '0;
    logic          write_ready, full;
    logic [SW-1:0] out;
`ifdef SOF_RESYNC_EN
    logic          block_start = 1'b0;
    logic [7:0]    resync_count;
`endif
    always #5 clk = ~clk;
    block_deserializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_valid  (write_valid),
        .block_data   (block_data),
        .write_ready  (write_ready),
        .read         (read),
        .full         (full),
`ifdef SOF_RESYNC_EN
        .block_start  (block_start),
        .resync_count (resync_count),
`endif
        .out          (out)
    );
    int            n_chk = 0, n_pass = 0, m_resync = 0, pulses = 0;
    logic          m_full = 1'b0;
    logic [7:0]    blk[$];
    logic [SW-1:0] m_out = '0;
    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic model_reset();
        m_full = 1'b0;
        blk.delete();
        m_resync = 0;
    endtask
    // One clock: drive, check ready, advance, update model, check outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic s);
        logic acc;
        write_valid = v;
        block_data = d;
        read = r;
`ifdef SOF_RESYNC_EN
        block_start = s;
`endif
        #1;
        check("write_ready", SW'(write_ready), SW'(!m_full || r));
        acc = v && (!m_full || r);
        @(posedge clk);
        #1;
        if (acc) begin
            if (m_full) begin
                m_full = 1'b0;
                blk = {d};
            end else if (SOF && s) begin
                if (blk.size() != 0 && m_resync < 255) m_resync++;
                blk = {d};
            end else blk.push_back(d);
            if (blk.size() == BB) begin
                m_out = '0;
                foreach (blk[k]) m_out = (m_out << 8) | SW'(blk[k]);
                m_full = 1'b1;
                blk.delete();
            end
        end else if (m_full && r) m_full = 1'b0;
        check("full", SW'(full), SW'(m_full));
        if (m_full) check("out", out, m_out);
`ifdef SOF_RESYNC_EN
        check("resync_count", SW'(resync_count), SW'(m_resync));
`endif
        if (full) pulses++;
    endtask
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_full", SW'(full), '0);
        check("rst_out", out, '0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    initial begin
        #1;
        check("reset_full", SW'(full), '0);
        check("reset_out", out, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < BB; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("first_msb", SW'(out[SW-1 -: 8]), SW'(8'h00));
        check("last_lsb", SW'(out[7:0]), SW'(8'h2B));
        check("ready_when_full", SW'(write_ready), '0);
        repeat (10) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("held_out_lsb", SW'(out[7:0]), SW'(8'h2B));
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("aa_full", SW'(full), '0);
        check("aa_msb", SW'(out[SW-1 -: 8]), SW'(8'hAA));
        repeat (BB - 2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("aa_not_yet", SW'(full), '0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("aa_block_full", SW'(full), SW'(1'b1));
        pulses = 0;
        repeat (3 * BB) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        check("stream_pulses", SW'(pulses), SW'(3));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (20) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        repeat (BB - 1) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("post_rst_not_yet", SW'(full), '0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        check("post_rst_full", SW'(full), SW'(1'b1));
        check("post_rst_lsb", SW'(out[7:0]), SW'(8'hC3));
        repeat (3000) step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
`ifdef SOF_RESYNC_EN
        do_reset();
        repeat (10) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check("sof_resync_one", SW'(resync_count), SW'(1));
        repeat (BB - 2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("sof_not_yet", SW'(full), '0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("sof_full", SW'(full), SW'(1'b1));
        check("sof_msb", SW'(out[SW-1 -: 8]), SW'(8'h55));
        repeat (256) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            step(1'b1, 8'($urandom), 1'b1, 1'b1);
        end
        check("sof_saturate", SW'(resync_count), SW'(255));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/block_deserializer.md
BLOCK_DESERIALIZER -- requirements
Module: block_deserializer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 44, meaning number of bytes per assembled block.
REQ-002 SHALL have parameter STATE_WIDTH, default 352 (8*BLOCK_BYTES), meaning width of the assembled output word.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port write_valid  input  1  block_data carries a valid byte.
REQ-006 SHALL have port block_data  input  8  incoming header byte.
REQ-007 SHALL have port write_ready  output  1  the block accepts a byte this cycle.
REQ-008 SHALL have port read  input  1  downstream consumes the assembled word.
REQ-009 SHALL have port full  output  1  out holds a complete, unconsumed block.
REQ-010 SHALL have port out  output  STATE_WIDTH  the assembled block.
REQ-011 SHALL have, under SOF_RESYNC_EN only: block_start  input  1  (accepted byte is byte 0) and resync_count  output  8  (count of discarded partial blocks).

Function
REQ-012 SHALL accept a byte exactly in cycles where write_valid & write_ready.
REQ-013 SHALL place accepted byte k (0-based) at out[STATE_WIDTH-1-8k -: 8]; the first byte is in the MSBs.
REQ-014 SHALL use a 6-bit byte counter 0..BLOCK_BYTES-1 and two states: FILL and FULL.
REQ-015 In FILL: each accepted byte increments the counter; accepting byte BLOCK_BYTES-1 sets the counter to 0 and enters FULL; full=1 from the next cycle.
REQ-016 In FULL: out SHALL be held stable; write_ready = read.
REQ-017 In FULL with read=1: the state SHALL return to FILL next cycle; a byte accepted in the same cycle becomes byte 0 of the next block, and the counter becomes 1.
REQ-018 In FILL: write_ready SHALL be 1; read SHALL be ignored.
REQ-019 write_ready SHALL be combinational from state and read only, never from write_valid.
REQ-020 Latency from acceptance of the last byte to full=1 SHALL be one cycle; a back-to-back stream with read tied high SHALL sustain one byte per cycle.
REQ-021 Bytes of a partial block in out are don't-care while full=0.

Reset
REQ-022 While rst_n=0: state=FILL, counter=0, full=0, out=0, resync_count=0 (when present); write_ready=1 after release.
REQ-023 A reset asserted mid-block or while FULL SHALL discard all content; no partial data survives.

Configuration
REQ-024 Macro SOF_RESYNC_EN: when defined, an accepted byte with block_start=1 in FILL SHALL be written as byte 0 and set the counter to 1.
REQ-025 Under the same macro, if the counter was nonzero at that point, resync_count SHALL increment, saturating at 255.
REQ-026 Under the same macro, block_start on a non-accepted cycle SHALL be ignored.
REQ-027 Under the same macro, when BLOCK_BYTES=1 and block_start=1, the block SHALL go FULL as in REQ-015.
REQ-028 Without the macro, block_start and resync_count SHALL be absent and framing SHALL rely solely on byte count.

Structure
REQ-029 Package bcx_pkg SHALL hold BLOCK_BYTES, STATE_WIDTH, the byte-count typedef, and the FILL/FULL state enum, all shared with block_storage.
REQ-030 One sub-module, byte_counter, SHALL hold the counter with load-0, load-1, increment, and wrap; the data register is a plain ff instance.

Verification
REQ-031 Reset, then 44 bytes 0x00..0x2B on consecutive cycles with read=0 -> full=1 one cycle after the 44th byte, out[351:344]=0x00, out[7:0]=0x2B, write_ready=0.
REQ-032 FULL, write_valid=1, read held 0 for 10 cycles -> out unchanged, no byte accepted; then read=1 with byte 0xAA -> full=0, counter=1, out[351:344]=0xAA.
REQ-033 Continuous stream of 3x44 bytes with read=1 -> no stall cycles, full pulses every 44 cycles with correct contents.
REQ-034 rst_n dropped asynchronously after 20 bytes, then released, then 44 bytes -> full after exactly 44 bytes, out holds only post-reset data.
REQ-035 SOF_RESYNC_EN: 10 bytes, then a byte 0x55 with block_start=1, then 43 bytes -> resync_count=1, out[351:344]=0x55, full after 44 bytes counted from 0x55; 256 resyncs -> resync_count=255.
